// File: rtl/even_pipe_exec.sv
// rtl/even_pipe_exec.sv - parametrised even-pipe execution unit with forwarding taps and writeback
module even_pipe_exec #(
    parameter int REG_DATA_WD = 128,
    parameter int REG_ADDR_WD = 7,
    parameter int DEPTH       = 7,
    parameter int LAT_IMM     = 2,
    parameter int LAT_FX      = 3,
    parameter int CNT_WD      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [2:0]                   in_op,
    input  logic [REG_ADDR_WD-1:0]       in_rt_addr,
    input  logic [REG_DATA_WD-1:0]       in_ra,
    input  logic [REG_DATA_WD-1:0]       in_rb,
    input  logic [6:0]                   in_i7,
    input  logic [15:0]                  in_i16,
    input  logic [17:0]                  in_i18,
    input  logic                         flush,
    output logic [DEPTH-1:0]             fwd_valid,
    output logic [DEPTH-1:0]             fwd_ready,
    output logic [DEPTH*REG_ADDR_WD-1:0] fwd_addr,
    output logic [DEPTH*REG_DATA_WD-1:0] fwd_data,
    output logic                         wb_en,
    output logic [REG_ADDR_WD-1:0]       wb_addr,
    output logic [REG_DATA_WD-1:0]       wb_data,
    output logic [CNT_WD-1:0]            issue_cnt
);

    localparam int NH = REG_DATA_WD / 16;
    localparam int NW = REG_DATA_WD / 32;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ILH   = 3'd1;
    localparam logic [2:0] OP_IL    = 3'd2;
    localparam logic [2:0] OP_ILA   = 3'd3;
    localparam logic [2:0] OP_SHLHI = 3'd4;
    localparam logic [2:0] OP_SHLI  = 3'd5;
    localparam logic [2:0] OP_AH    = 3'd6;
    localparam logic [2:0] OP_A     = 3'd7;

    // Class bit per stage: 0 = immediate load, 1 = shift/add
    localparam logic CLS_IMM = 1'b0;
    localparam logic CLS_FX  = 1'b1;

    logic [DEPTH-1:0]                  valid_q, valid_d;
    logic [DEPTH-1:0]                  cls_q, cls_d;
    logic [DEPTH-1:0][REG_ADDR_WD-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][REG_DATA_WD-1:0] data_q, data_d;
    logic [CNT_WD-1:0]                 cnt_q, cnt_d;

    logic                   accept;
    logic [REG_DATA_WD-1:0] result;
    logic [4:0]             sh_h;
    logic [5:0]             sh_w;
    logic                   unused_i7_msb;

    assign sh_h          = in_i7[4:0];
    assign sh_w          = in_i7[5:0];
    assign unused_i7_msb = in_i7[6];
    assign accept        = in_valid && (in_op != OP_NOP) && !flush;

    // Lane-wise result for the issued op; computed once at issue and then only shifted
    always_comb begin
        result = '0;
        case (in_op)
            OP_ILH: begin
                for (int h = 0; h < NH; h++) begin
                    result[h*16 +: 16] = in_i16;
                end
            end
            OP_IL: begin
                for (int w = 0; w < NW; w++) begin
                    result[w*32 +: 32] = {{16{in_i16[15]}}, in_i16};
                end
            end
            OP_ILA: begin
                for (int w = 0; w < NW; w++) begin
                    result[w*32 +: 32] = {14'd0, in_i18};
                end
            end
            OP_SHLHI: begin
                for (int h = 0; h < NH; h++) begin
                    result[h*16 +: 16] = (sh_h >= 5'd16) ? 16'd0 : (in_ra[h*16 +: 16] << sh_h);
                end
            end
            OP_SHLI: begin
                for (int w = 0; w < NW; w++) begin
                    result[w*32 +: 32] = (sh_w >= 6'd32) ? 32'd0 : (in_ra[w*32 +: 32] << sh_w);
                end
            end
            OP_AH: begin
                for (int h = 0; h < NH; h++) begin
                    result[h*16 +: 16] = in_ra[h*16 +: 16] + in_rb[h*16 +: 16];
                end
            end
            OP_A: begin
                for (int w = 0; w < NW; w++) begin
                    result[w*32 +: 32] = in_ra[w*32 +: 32] + in_rb[w*32 +: 32];
                end
            end
            default: result = '0;
        endcase
    end

    // Next state: capture into stage 1, shift the rest, flush clears every valid bit
    always_comb begin
        valid_d   = '0;
        cls_d     = '0;
        addr_d    = '0;
        data_d    = '0;
        valid_d[0] = accept;
        cls_d[0]   = (in_op >= OP_SHLHI) ? CLS_FX : CLS_IMM;
        addr_d[0]  = accept ? in_rt_addr : '0;
        data_d[0]  = accept ? result : '0;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1] && !flush;
            cls_d[i]   = cls_q[i-1];
            addr_d[i]  = addr_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        cnt_d = cnt_q + CNT_WD'(accept);
    end

    // Pipeline and counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            cls_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cls_q   <= cls_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Forwarding taps straight from stage flops; data masked until the class latency is reached
    always_comb begin
        fwd_ready = '0;
        fwd_addr  = '0;
        fwd_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_ready[k] = valid_q[k] && (((cls_q[k] == CLS_FX) ? LAT_FX : LAT_IMM) <= (k + 1));
            fwd_addr[k*REG_ADDR_WD +: REG_ADDR_WD] = addr_q[k];
            fwd_data[k*REG_DATA_WD +: REG_DATA_WD] = fwd_ready[k] ? data_q[k] : '0;
        end
    end

    assign fwd_valid = valid_q;
    assign wb_en     = valid_q[DEPTH-1];
    assign wb_addr   = addr_q[DEPTH-1];
    assign wb_data   = data_q[DEPTH-1];
    assign issue_cnt = cnt_q;

endmodule

// File: doc/even_pipe_exec.md
# even_pipe_exec

Parametrised even-pipe execution unit, successor to the single-stage even pipe. It takes one issued even-pipe instruction per cycle and computes the result for its op class. The result travels down a DEPTH-stage result shift register that ends in writeback. Every stage drives a forwarding tap with a ready flag that follows the op's class latency. The block also supports flush and keeps an issue counter.

## Interface
- REG_DATA_WD, 128, register width in bits; multiple of 32
- REG_ADDR_WD, 7, register-file address width
- DEPTH, 7, number of pipeline stages from issue to writeback; 2..15
- LAT_IMM, 2, stage at which immediate-load results become ready; 1..DEPTH
- LAT_FX, 3, stage at which shift/add results become ready; LAT_IMM..DEPTH
- CNT_WD, 16, issue-counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction issued this cycle
- in_op  in  3  0 NOP, 1 ILH, 2 IL, 3 ILA, 4 SHLHI, 5 SHLI, 6 AH, 7 A
- in_rt_addr  in  REG_ADDR_WD  destination register
- in_ra, in_rb  in  REG_DATA_WD  source operands
- in_i7  in  7  shift immediate
- in_i16  in  16  load immediate
- in_i18  in  18  address immediate
- flush  in  1  kill all in-flight instructions
- fwd_valid  out  DEPTH  per-stage occupied flag; bit k-1 is stage k
- fwd_ready  out  DEPTH  per-stage result-ready flag
- fwd_addr  out  DEPTH*REG_ADDR_WD  per-stage destination address, packed with stage 1 at the LSBs
- fwd_data  out  DEPTH*REG_DATA_WD  per-stage result, packed; zero when not ready
- wb_en, wb_addr, wb_data  out  1 / REG_ADDR_WD / REG_DATA_WD  writeback port, equal to stage DEPTH
- issue_cnt  out  CNT_WD  number of accepted non-NOP instructions, wraps

## Operation
- Accept: the instruction is captured into stage 1 when in_valid=1, in_op!=0 and flush=0. A NOP, or in_valid=0, puts a bubble (valid=0) into stage 1.
- Issue counter: issue_cnt increments by 1 on each accept and wraps from 2^CNT_WD-1 to 0.
- Per-stage state:
  - Stored fields are valid, cls (IMM for ops 1-3, FX for ops 4-7), addr and data.
  - The result is computed at issue and stored in stage 1; later stages only shift it.
- Ready rule: stage k has fwd_ready=1 when valid=1 and k>=LAT of the stage's class. fwd_data for stage k is the stored data when ready, otherwise 0.
- Arithmetic. H means 16-bit lanes and W means 32-bit lanes across REG_DATA_WD:
  - ILH: every H lane = in_i16.
  - IL: every W lane = sign-extended in_i16.
  - ILA: every W lane = zero-extended in_i18.
  - SHLHI: s = in_i7[4:0]. Each H lane of in_ra is shifted left by s, with bits shifted out discarded. If s>=16, the lane is 0.
  - SHLI: s = in_i7[5:0]. Each W lane of in_ra is shifted left by s. If s>=32, the lane is 0.
  - AH: each H lane = (ra+rb) mod 2^16.
  - A: each W lane = (ra+rb) mod 2^32.
  - No flags or exceptions.
- Flush:
  - On an edge with flush=1, every stage's valid bit becomes 0 and the input is not captured.
  - wb outputs for the flush cycle itself still show the pre-edge stage DEPTH.
  - issue_cnt does not count the input dropped by flush.

## Timing
- Stage k holds an instruction exactly k cycles after its issue edge. Writeback happens DEPTH cycles after issue.
- Throughput is one instruction per cycle, with no stalls and no backpressure.
- Forwarding latency is LAT_IMM for IMM-class ops and LAT_FX for FX-class ops, counted in cycles after issue.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (asynchronous; takes effect immediately, including mid-stream):
  - All valid bits = 0.
  - fwd_* = 0.
  - wb_en = 0, wb_addr = 0, wb_data = 0.
  - issue_cnt = 0.
- The first accept is possible on the first clock edge after rst deasserts.
- Back-to-back issues to the same rt_addr occupy consecutive stages independently. Priority between them belongs to the consumer, with the youngest stage winning.

## Test plan
- ILH with in_i16=16'h1234, rt=5:
  - fwd_ready goes high at stage 2 (cycle 2).
  - wb_en=1 at cycle 7 with wb_addr=5 and wb_data=128'h1234…1234.
- IL with in_i16=16'h8001 followed back-to-back by ILA with in_i18=18'h3ffff:
  - Writebacks on consecutive cycles.
  - Word lanes are 32'hffff8001 and 32'h0003ffff.
- SHLHI with ra halfwords=16'h2132:
  - in_i7=7'h04 gives 16'h1320.
  - in_i7=7'h44 gives 16'h1320 (only [4:0] used).
  - in_i7=7'h10 gives 0.
  - fwd_data is 0 at stages 1-2 and ready at stage 3.
- A/AH wrap:
  - A with 32'hffffffff + 1 gives 0 in every word.
  - AH with 16'hffff + 16'h0002 gives 16'h0001 in every halfword.
- Flush with 4 instructions in flight:
  - All fwd_valid are 0 after the edge.
  - No further wb_en for those instructions.
  - issue_cnt stays at 4.
- Reset and counter:
  - Assert rst asynchronously mid-stream; all outputs are 0 immediately.
  - With CNT_WD=4, 17 accepts then give issue_cnt=1, and NOPs are not counted.
